// File: rtl/writeback_grf.sv
// Writeback-stage general register file.
// Decodes the W-stage bundle into a destination register and write data,
// commits it to the 32x32 register file, serves the two D-stage read ports
// with same-cycle write-through bypass, and exports the W-stage write target
// to the forwarding network.

// One D-stage read port: $0 reads zero, a matching W-stage write is
// bypassed so the reader sees the value being committed this cycle.
module writeback_grf_rdport #(
  parameter int WIDTH = 32
) (
  input  logic [4:0]             addr,
  input  logic [31:0][WIDTH-1:0] regs,
  input  logic                   wr_en,
  input  logic [4:0]             waddr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       data
);

  // Zero for $0, bypass on a W-stage hit, otherwise the stored value.
  always_comb begin
    data = '0;
    if (addr != 5'd0) begin
      if (wr_en && (addr == waddr)) data = wdata;
      else                          data = regs[addr];
    end
  end

endmodule

module writeback_grf #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int          WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      instruct_W,
  input  logic [WIDTH-1:0] ALU_result_W,
  input  logic [WIDTH-1:0] Mem_Data_W,
  input  logic [2:0]       FWD_T_new_W,
  input  logic [4:0]       rs_addr_D,
  input  logic [4:0]       rt_addr_D,
  output logic [WIDTH-1:0] rs_data_D,
  output logic [WIDTH-1:0] rt_data_D,
  output logic             wr_en_W,
  output logic [4:0]       fwd_addr_W,
  output logic [WIDTH-1:0] fwd_data_W,
  output logic             t_new_err
);

  localparam int NUM_RD = 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  logic [5:0]       opcode, funct;
  logic [4:0]       rt, rd;
  logic             dec_wr;
  logic [4:0]       dec_dest;
  logic [WIDTH-1:0] dec_data;

  // Register fields / shamt are not needed for writeback decode.
  logic unused_fields;
  assign unused_fields = ^{instruct_W[25:21], instruct_W[10:6]};

  assign opcode = instruct_W[31:26];
  assign funct  = instruct_W[5:0];
  assign rt     = instruct_W[20:16];
  assign rd     = instruct_W[15:11];

  // Destination and data-source decode; anything unlisted never writes.
  always_comb begin
    dec_wr   = 1'b0;
    dec_dest = 5'd0;
    dec_data = '0;
    unique case (opcode)
      OP_RTYPE: if (funct == FN_ADD || funct == FN_SUB) begin
        dec_wr   = 1'b1;
        dec_dest = rd;
        dec_data = ALU_result_W;
      end
      OP_ORI, OP_LUI: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        dec_data = ALU_result_W;
      end
      OP_LW: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        dec_data = Mem_Data_W;
      end
      OP_JAL: begin
        dec_wr   = 1'b1;
        dec_dest = 5'd31;
        dec_data = PC_W + LINK_OFFSET;
      end
      default: ;
    endcase
  end

  // Writes to $0 are dropped here so everything downstream sees no write.
  assign wr_en_W    = dec_wr && (dec_dest != 5'd0);
  assign fwd_addr_W = wr_en_W ? dec_dest : 5'd0;
  assign fwd_data_W = wr_en_W ? dec_data : '0;

  // Register file. Entry 0 is cleared by reset and never written because
  // wr_en_W excludes dest 0, so it reads as a hardwired zero.
  logic [31:0][WIDTH-1:0] regs;

  // Commit the W-stage write; async reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (wr_en_W) begin
      regs[fwd_addr_W] <= fwd_data_W;
    end
  end

  // Sticky protocol error: a writing instruction reached W still owing T_new.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   t_new_err <= 1'b0;
    else if (wr_en_W && (FWD_T_new_W != 3'd0))    t_new_err <= 1'b1;
  end

  // Read ports share one implementation; packed arrays map them to ports.
  logic [NUM_RD-1:0][4:0]       rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_data;

  assign rd_addr[0] = rs_addr_D;
  assign rd_addr[1] = rt_addr_D;
  assign rs_data_D  = rd_data[0];
  assign rt_data_D  = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    writeback_grf_rdport #(.WIDTH(WIDTH)) u_rdport (
      .addr  (rd_addr[p]),
      .regs  (regs),
      .wr_en (wr_en_W),
      .waddr (fwd_addr_W),
      .wdata (fwd_data_W),
      .data  (rd_data[p])
    );
  end

endmodule

// File: tb/tb_writeback_grf.sv
// Directed bench for writeback_grf: each task drives one scenario and checks
// hand-computed values inline.
module tb_writeback_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_W = '0, instruct_W = '0, ALU_result_W = '0, Mem_Data_W = '0;
  logic [2:0]  FWD_T_new_W = '0;
  logic [4:0]  rs_addr_D = '0, rt_addr_D = '0;
  logic [31:0] rs_data_D, rt_data_D, fwd_data_W;
  logic        wr_en_W, t_new_err;
  logic [4:0]  fwd_addr_W;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_grf #(.LINK_OFFSET(32'd8), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .PC_W(PC_W), .instruct_W(instruct_W),
    .ALU_result_W(ALU_result_W), .Mem_Data_W(Mem_Data_W),
    .FWD_T_new_W(FWD_T_new_W), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .rs_data_D(rs_data_D), .rt_data_D(rt_data_D), .wr_en_W(wr_en_W),
    .fwd_addr_W(fwd_addr_W), .fwd_data_W(fwd_data_W), .t_new_err(t_new_err)
  );

  always #5 clk = ~clk;

  // Drive a W bundle; stimulus only.
  task automatic set_w(input logic [31:0] pc, ins, alu, mem, input logic [2:0] tn);
    PC_W = pc; instruct_W = ins; ALU_result_W = alu; Mem_Data_W = mem; FWD_T_new_W = tn;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rs_addr_D = 5'd5; rt_addr_D = 5'd5;
    #1;
    n_cmp++; if (rs_data_D !== 32'h0) begin n_bad++; $display("FAIL reset_rs got=%h exp=%h", rs_data_D, 32'h0); end
    n_cmp++; if (t_new_err !== 1'b0) begin n_bad++; $display("FAIL reset_tnerr got=%b exp=0", t_new_err); end
    tick();
    reset = 1'b1;
    set_w(32'h0, 32'h3405_1234, 32'h0000_1234, 32'h0, 3'd0);
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    #1;
    n_cmp++; if (rs_data_D !== 32'h1234) begin n_bad++; $display("FAIL reset_pre got=%h exp=%h", rs_data_D, 32'h1234); end
    // Async assert between edges: the clear must be visible before any edge.
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (rs_data_D !== 32'h0) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", rs_data_D, 32'h0); end
    n_cmp++; if (t_new_err !== 1'b0) begin n_bad++; $display("FAIL reset_async_tn got=%b exp=0", t_new_err); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_ori();
    rs_addr_D = 5'd5; rt_addr_D = 5'd0;
    set_w(32'h0, 32'h3405_00FF, 32'h0000_00FF, 32'h0, 3'd0);
    #1;
    n_cmp++; if (rs_data_D !== 32'hFF) begin n_bad++; $display("FAIL ori_bypass got=%h exp=%h", rs_data_D, 32'hFF); end
    n_cmp++; if (fwd_addr_W !== 5'd5) begin n_bad++; $display("FAIL ori_addr got=%0d exp=5", fwd_addr_W); end
    n_cmp++; if (wr_en_W !== 1'b1) begin n_bad++; $display("FAIL ori_wren got=%b exp=1", wr_en_W); end
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    #1;
    n_cmp++; if (rs_data_D !== 32'hFF) begin n_bad++; $display("FAIL ori_stored got=%h exp=%h", rs_data_D, 32'hFF); end
    // lui $10 writes rt with ALU data
    set_w(32'h0, 32'h3C0A_1234, 32'h1234_0000, 32'h5555_5555, 3'd0);
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    rt_addr_D = 5'd10; #1;
    n_cmp++; if (rt_data_D !== 32'h1234_0000) begin n_bad++; $display("FAIL lui_stored got=%h exp=%h", rt_data_D, 32'h1234_0000); end
  endtask

  task automatic test_rtype();
    // add $8 then sub $9 back to back
    set_w(32'h0, 32'h0022_4020, 32'h0000_0011, 32'h0, 3'd0);
    #1;
    n_cmp++; if (fwd_addr_W !== 5'd8) begin n_bad++; $display("FAIL add_addr got=%0d exp=8", fwd_addr_W); end
    tick();
    set_w(32'h0, 32'h0022_4822, 32'hFFFF_FFF0, 32'h0, 3'd0);
    rs_addr_D = 5'd8; rt_addr_D = 5'd9; #1;
    n_cmp++; if (rs_data_D !== 32'h11) begin n_bad++; $display("FAIL add_stored got=%h exp=%h", rs_data_D, 32'h11); end
    n_cmp++; if (rt_data_D !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL sub_bypass got=%h exp=%h", rt_data_D, 32'hFFFF_FFF0); end
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0); #1;
    n_cmp++; if (rt_data_D !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL sub_stored got=%h exp=%h", rt_data_D, 32'hFFFF_FFF0); end
  endtask

  task automatic test_jal();
    rs_addr_D = 5'd31; rt_addr_D = 5'd0;
    set_w(32'h0000_3010, 32'h0C00_0000, 32'h0, 32'h0, 3'd0);
    #1;
    n_cmp++; if (fwd_addr_W !== 5'd31) begin n_bad++; $display("FAIL jal_addr got=%0d exp=31", fwd_addr_W); end
    n_cmp++; if (fwd_data_W !== 32'h0000_3018) begin n_bad++; $display("FAIL jal_data got=%h exp=%h", fwd_data_W, 32'h3018); end
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0); #1;
    n_cmp++; if (rs_data_D !== 32'h0000_3018) begin n_bad++; $display("FAIL jal_stored got=%h exp=%h", rs_data_D, 32'h3018); end
    set_w(32'hFFFF_FFFC, 32'h0C00_0000, 32'h0, 32'h0, 3'd0); #1;
    n_cmp++; if (fwd_data_W !== 32'h0000_0004) begin n_bad++; $display("FAIL jal_wrap got=%h exp=%h", fwd_data_W, 32'h4); end
    tick();
  endtask

  task automatic test_nowrite();
    logic [31:0] ins [5];
    ins[0] = 32'h0022_0020; // add $0
    ins[1] = 32'hAC05_0000; // sw rt=5
    ins[2] = 32'h10A5_0004; // beq
    ins[3] = 32'h03E0_0008; // jr $31
    ins[4] = 32'h0000_0000; // nop
    rs_addr_D = 5'd0; rt_addr_D = 5'd5;
    for (int i = 0; i < 5; i++) begin
      set_w(32'h0000_4000, ins[i], 32'h0000_DEAD, 32'h0000_BEEF, 3'd0);
      #1;
      n_cmp++; if (wr_en_W !== 1'b0) begin n_bad++; $display("FAIL nowr_wren[%0d] got=%b exp=0", i, wr_en_W); end
      n_cmp++; if (fwd_addr_W !== 5'd0) begin n_bad++; $display("FAIL nowr_addr[%0d] got=%0d exp=0", i, fwd_addr_W); end
      n_cmp++; if (fwd_data_W !== 32'h0) begin n_bad++; $display("FAIL nowr_data[%0d] got=%h exp=0", i, fwd_data_W); end
      n_cmp++; if (rs_data_D !== 32'h0) begin n_bad++; $display("FAIL nowr_r0[%0d] got=%h exp=0", i, rs_data_D); end
      tick();
      n_cmp++; if (rt_data_D !== 32'hFF) begin n_bad++; $display("FAIL nowr_r5[%0d] got=%h exp=%h", i, rt_data_D, 32'hFF); end
    end
    rt_addr_D = 5'd31; #1;
    n_cmp++; if (rt_data_D !== 32'h0000_0004) begin n_bad++; $display("FAIL nowr_r31 got=%h exp=%h", rt_data_D, 32'h4); end
  endtask

  task automatic test_lw();
    set_w(32'h0, 32'h8C07_0000, 32'h0000_0040, 32'hCAFE_BABE, 3'd0);
    rs_addr_D = 5'd7; rt_addr_D = 5'd7; #1;
    n_cmp++; if (fwd_data_W !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL lw_fwd got=%h exp=%h", fwd_data_W, 32'hCAFE_BABE); end
    tick();
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0); #1;
    n_cmp++; if (rs_data_D !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL lw_rs got=%h exp=%h", rs_data_D, 32'hCAFE_BABE); end
    n_cmp++; if (rt_data_D !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL lw_rt got=%h exp=%h", rt_data_D, 32'hCAFE_BABE); end
  endtask

  task automatic test_tnew();
    // Nonzero T_new on a non-writer must not flag.
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd2);
    tick();
    n_cmp++; if (t_new_err !== 1'b0) begin n_bad++; $display("FAIL tn_nowrite got=%b exp=0", t_new_err); end
    set_w(32'h0, 32'h8C07_0000, 32'h0, 32'h1111_2222, 3'd1);
    #1;
    n_cmp++; if (t_new_err !== 1'b0) begin n_bad++; $display("FAIL tn_pre got=%b exp=0", t_new_err); end
    tick();
    n_cmp++; if (t_new_err !== 1'b1) begin n_bad++; $display("FAIL tn_set got=%b exp=1", t_new_err); end
    set_w(32'h0, 32'h3405_0077, 32'h77, 32'h0, 3'd0);
    tick(); tick();
    n_cmp++; if (t_new_err !== 1'b1) begin n_bad++; $display("FAIL tn_sticky got=%b exp=1", t_new_err); end
    set_w(32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (t_new_err !== 1'b0) begin n_bad++; $display("FAIL tn_clear got=%b exp=0", t_new_err); end
    #1 reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_ori();
    test_rtype();
    test_jal();
    test_nowrite();
    test_lw();
    test_tnew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
